// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM states and oversampling constants for uart_stream
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_stream_fifo.sv
// rtl/uart_stream_fifo.sv - show-ahead FIFO, 2^W words of B bits, with occupancy level
module uart_stream_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [B-1:0] wdata,
    input  logic         rd,
    output logic [B-1:0] rdata,
    output logic         full,
    output logic         empty,
    output logic [W:0]   level
);

    localparam logic [W:0] PTR_ONE = {{W{1'b0}}, 1'b1};

    logic [B-1:0] mem [2**W];
    logic [W:0]   wptr_q, rptr_q;
    logic         rd_ok, wr_ok;

    // A write into a full FIFO is only accepted when a pop frees the slot in the same cycle
    always_comb begin
        level = wptr_q - rptr_q;
        full  = level[W];
        empty = (level == '0);
        rd_ok = rd && !empty;
        wr_ok = wr && (!full || rd_ok);
        rdata = mem[rptr_q[W-1:0]];
    end

    // Storage array, written only on an accepted push
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr_q[W-1:0]] <= wdata;
        end
    end

    // Pointers carry one extra bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + PTR_ONE;
            if (rd_ok) rptr_q <= rptr_q + PTR_ONE;
        end
    end

endmodule

// File: rtl/uart_stream.sv
// rtl/uart_stream.sv - buffered full-duplex UART with streaming ports; UART_PARITY_EN adds even parity
module uart_stream
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR_W  = 16,
    parameter int FIFO_W  = 4
) (
    input  logic              pclk,
    input  logic              rst_n,
    input  logic [DVSR_W-1:0] dvsr,
    input  logic              rx,
    output logic              tx,
    input  logic [DBIT-1:0]   tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DBIT-1:0]   rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [FIFO_W:0]   rx_level,
    output logic              tx_busy,
    output logic              rx_overrun,
    output logic              rx_frame_err,
    output logic              rx_parity_err
);

    logic [DVSR_W-1:0] cnt_q, cnt_d, term_m1;
    logic              tick;

    logic              txf_wr, txf_rd, txf_full, txf_empty;
    logic [DBIT-1:0]   txf_rdata;
    logic [FIFO_W:0]   txf_level;
    logic              rxf_full, rxf_empty;

    uart_state_e       tx_state_q, tx_state_d;
    logic [4:0]        tx_s_q, tx_s_d;
    logic [3:0]        tx_n_q, tx_n_d;
    logic [DBIT-1:0]   tx_b_q, tx_b_d;
    logic              tx_q, tx_d;

    uart_state_e       rx_state_q, rx_state_d;
    logic [4:0]        rx_s_q, rx_s_d;
    logic [3:0]        rx_n_q, rx_n_d;
    logic [DBIT-1:0]   rx_b_q, rx_b_d;
    logic              rx_s1_q, rx_s2_q, rx_s3_q;
    logic              rx_push_q, rx_push_d;
    logic              rx_ferr_q, rx_ferr_d;
`ifdef UART_PARITY_EN
    logic              tx_par_q, tx_par_d;
    logic              rx_par_q, rx_par_d;
    logic              rx_perr_q, rx_perr_d;
`endif

    // Baud tick: divisor change is seen at once, an overshooting count wraps on the spot
    always_comb begin
        term_m1 = (dvsr == '0) ? '0 : dvsr - DVSR_W'(1);
        tick    = (cnt_q >= term_m1);
        cnt_d   = tick ? '0 : cnt_q + DVSR_W'(1);
    end

    assign txf_wr   = tx_valid && !txf_full;
    assign tx_ready = !txf_full;
    assign tx_busy  = (txf_level != '0) || (tx_state_q != ST_IDLE);
    assign tx       = tx_q;

    uart_stream_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
        .clk(pclk), .rst_n(rst_n), .wr(txf_wr), .wdata(tx_data), .rd(txf_rd),
        .rdata(txf_rdata), .full(txf_full), .empty(txf_empty), .level(txf_level)
    );

    uart_stream_fifo #(.B(DBIT), .W(FIFO_W)) u_rx_fifo (
        .clk(pclk), .rst_n(rst_n), .wr(rx_push_q), .wdata(rx_b_q), .rd(rx_ready),
        .rdata(rx_data), .full(rxf_full), .empty(rxf_empty), .level(rx_level)
    );

    assign rx_valid     = !rxf_empty;
    assign rx_overrun   = rx_push_q && rxf_full && !rx_ready;
    assign rx_frame_err = rx_ferr_q;
`ifdef UART_PARITY_EN
    assign rx_parity_err = rx_perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

    // TX FSM: pops a word in IDLE or at the end of STOP so queued frames run back to back
    always_comb begin
        tx_state_d = tx_state_q;
        tx_s_d     = tx_s_q;
        tx_n_d     = tx_n_q;
        tx_b_d     = tx_b_q;
        txf_rd     = 1'b0;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        case (tx_state_q)
            ST_IDLE: if (!txf_empty) begin
                txf_rd     = 1'b1;
                tx_b_d     = txf_rdata;
`ifdef UART_PARITY_EN
                tx_par_d   = ^txf_rdata;
`endif
                tx_s_d     = '0;
                tx_state_d = ST_START;
            end
            ST_START: if (tick) begin
                if (tx_s_q == 5'(OVERSAMPLE - 1)) begin
                    tx_s_d     = '0;
                    tx_n_d     = '0;
                    tx_state_d = ST_DATA;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_DATA: if (tick) begin
                if (tx_s_q == 5'(OVERSAMPLE - 1)) begin
                    tx_s_d = '0;
                    tx_b_d = tx_b_q >> 1;
                    if (tx_n_q == 4'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                        tx_state_d = ST_PARITY;
`else
                        tx_state_d = ST_STOP;
`endif
                    end else tx_n_d = tx_n_q + 4'd1;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_PARITY: if (tick) begin
                if (tx_s_q == 5'(OVERSAMPLE - 1)) begin
                    tx_s_d     = '0;
                    tx_state_d = ST_STOP;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            ST_STOP: if (tick) begin
                if (tx_s_q == 5'(SB_TICK - 1)) begin
                    tx_s_d = '0;
                    if (!txf_empty) begin
                        txf_rd     = 1'b1;
                        tx_b_d     = txf_rdata;
`ifdef UART_PARITY_EN
                        tx_par_d   = ^txf_rdata;
`endif
                        tx_state_d = ST_START;
                    end else tx_state_d = ST_IDLE;
                end else tx_s_d = tx_s_q + 5'd1;
            end
            default: tx_state_d = ST_IDLE;
        endcase
    end

    // Line level follows the current state, registered so the pin is glitch-free
    always_comb begin
        case (tx_state_q)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_b_q[0];
`ifdef UART_PARITY_EN
            ST_PARITY: tx_d = tx_par_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // RX FSM: start confirmed mid-bit, data and stop sampled one bit period apart
    always_comb begin
        rx_state_d = rx_state_q;
        rx_s_d     = rx_s_q;
        rx_n_d     = rx_n_q;
        rx_b_d     = rx_b_q;
        rx_push_d  = 1'b0;
        rx_ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_d   = rx_par_q;
        rx_perr_d  = 1'b0;
`endif
        case (rx_state_q)
            ST_IDLE: if (rx_s3_q && !rx_s2_q) begin
                rx_s_d     = '0;
                rx_state_d = ST_START;
            end
            ST_START: if (tick) begin
                if (rx_s_q == 5'(MID_TICK)) begin
                    rx_s_d     = '0;
                    rx_n_d     = '0;
                    rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_DATA: if (tick) begin
                if (rx_s_q == 5'(OVERSAMPLE - 1)) begin
                    rx_s_d = '0;
                    rx_b_d = {rx_s2_q, rx_b_q[DBIT-1:1]};
                    if (rx_n_q == 4'(DBIT - 1)) begin
`ifdef UART_PARITY_EN
                        rx_state_d = ST_PARITY;
`else
                        rx_state_d = ST_STOP;
`endif
                    end else rx_n_d = rx_n_q + 4'd1;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_PARITY: if (tick) begin
                if (rx_s_q == 5'(OVERSAMPLE - 1)) begin
                    rx_s_d     = '0;
`ifdef UART_PARITY_EN
                    rx_par_d   = rx_s2_q;
`endif
                    rx_state_d = ST_STOP;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            ST_STOP: if (tick) begin
                if (rx_s_q == 5'(OVERSAMPLE - 1)) begin
                    rx_s_d     = '0;
                    rx_state_d = ST_IDLE;
                    if (!rx_s2_q) rx_ferr_d = 1'b1;
`ifdef UART_PARITY_EN
                    else if (rx_par_q != ^rx_b_q) rx_perr_d = 1'b1;
`endif
                    else rx_push_d = 1'b1;
                end else rx_s_d = rx_s_q + 5'd1;
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any frame in flight and idles the line high
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tx_state_q <= ST_IDLE;
            tx_s_q     <= '0;
            tx_n_q     <= '0;
            tx_b_q     <= '0;
            tx_q       <= 1'b1;
            rx_state_q <= ST_IDLE;
            rx_s_q     <= '0;
            rx_n_q     <= '0;
            rx_b_q     <= '0;
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_push_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
            rx_par_q   <= 1'b0;
            rx_perr_q  <= 1'b0;
`endif
        end else begin
            cnt_q      <= cnt_d;
            tx_state_q <= tx_state_d;
            tx_s_q     <= tx_s_d;
            tx_n_q     <= tx_n_d;
            tx_b_q     <= tx_b_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_s_q     <= rx_s_d;
            rx_n_q     <= rx_n_d;
            rx_b_q     <= rx_b_d;
            rx_s1_q    <= rx;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_push_q  <= rx_push_d;
            rx_ferr_q  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
            rx_par_q   <= rx_par_d;
            rx_perr_q  <= rx_perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_stream.sv
// tb/tb_uart_stream.sv - directed self-checking bench for uart_stream
module tb_uart_stream;

    localparam int DBIT   = 8;
    localparam int FIFO_W = 2;
    localparam int DVSR_W = 16;

    logic              pclk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DVSR_W-1:0] dvsr = 16'd3;
    logic              rx_drv = 1'b1;
    logic              loop_en = 1'b0;
    logic              rx_w;
    logic              tx;
    logic [DBIT-1:0]   tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DBIT-1:0]   rx_data;
    logic              rx_valid;
    logic              rx_ready = 1'b0;
    logic [FIFO_W:0]   rx_level;
    logic              tx_busy, rx_overrun, rx_frame_err, rx_parity_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ovr_cnt = 0, fer_cnt = 0, per_cnt = 0;

    assign rx_w = loop_en ? tx : rx_drv;

    uart_stream #(.DBIT(DBIT), .SB_TICK(16), .DVSR_W(DVSR_W), .FIFO_W(FIFO_W)) dut (
        .pclk(pclk), .rst_n(rst_n), .dvsr(dvsr), .rx(rx_w), .tx(tx),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .rx_level(rx_level), .tx_busy(tx_busy), .rx_overrun(rx_overrun),
        .rx_frame_err(rx_frame_err), .rx_parity_err(rx_parity_err)
    );

    always #5 pclk = ~pclk;

    always @(posedge pclk) cyc <= cyc + 1;

    always @(negedge pclk) begin
        if (rx_overrun)    ovr_cnt++;
        if (rx_frame_err)  fer_cnt++;
        if (rx_parity_err) per_cnt++;
    end

    // Drive one serial frame on rx at 32 pclk per bit (dvsr=2)
    task automatic send_rx_frame(input logic [7:0] d, input logic stop_bit);
        @(negedge pclk);
        rx_drv = 1'b0;
        repeat (32) @(negedge pclk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = d[i];
            repeat (32) @(negedge pclk);
        end
`ifdef UART_PARITY_EN
        rx_drv = ^d;
        repeat (32) @(negedge pclk);
`endif
        rx_drv = stop_bit;
        repeat (32) @(negedge pclk);
        rx_drv = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge pclk);
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", tx); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
        checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL reset_rx_level got %0d exp 0", rx_level); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy got %b exp 0", tx_busy); end
        checks++;
        if ({rx_overrun, rx_frame_err, rx_parity_err} !== 3'b000) begin
            errors++; $display("FAIL reset_err_pulses got %b exp 000", {rx_overrun, rx_frame_err, rx_parity_err});
        end
        @(negedge pclk);
        rst_n = 1'b1;
        repeat (4) @(negedge pclk);
    endtask

    task automatic test_tx_frame();
        logic [7:0] exp_bits;
        int t0;
        int guard;
        exp_bits = 8'hA5;
        dvsr = 16'd3;
        @(negedge pclk);
        tx_data = 8'hA5;
        tx_valid = 1'b1;
        @(posedge pclk);
        #1 tx_valid = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_lat_n got %b exp 1", tx); end
        @(posedge pclk); #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_lat_n1 got %b exp 1", tx); end
        @(posedge pclk); #1;
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL tx_lat_n2 got %b exp 0", tx); end
        t0 = cyc;
        repeat (72) @(posedge pclk);
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (tx !== exp_bits[k]) begin errors++; $display("FAIL tx_bit%0d got %b exp %b", k, tx, exp_bits[k]); end
            repeat (48) @(posedge pclk);
        end
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL tx_stop got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL tx_busy_in_stop got %b exp 1", tx_busy); end
        guard = 0;
        while (tx_busy === 1'b1 && guard < 200) begin
            @(posedge pclk); #1;
            guard++;
        end
        checks++;
        if ((cyc - t0) < 470 || (cyc - t0) > 490) begin
            errors++; $display("FAIL tx_busy_fall got %0d cycles exp 470..490", cyc - t0);
        end
    endtask

    task automatic test_loopback();
        logic [7:0] words [4];
        logic [7:0] got [4];
        int n;
        int guard;
        int fer0, ovr0, per0;
        words[0] = 8'h00; words[1] = 8'hFF; words[2] = 8'h5A; words[3] = 8'hC3;
        fer0 = fer_cnt; ovr0 = ovr_cnt; per0 = per_cnt;
        dvsr = 16'd2;
        rx_ready = 1'b1;
        @(negedge pclk);
        loop_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge pclk);
            guard = 0;
            while (!tx_ready && guard < 2000) begin @(negedge pclk); guard++; end
            tx_data = words[i];
            tx_valid = 1'b1;
            @(posedge pclk);
            #1 tx_valid = 1'b0;
        end
        n = 0;
        guard = 0;
        while (n < 4 && guard < 3000) begin
            @(posedge pclk); #1;
            if (rx_valid) begin got[n] = rx_data; n++; end
            guard++;
        end
        checks++; if (n != 4) begin errors++; $display("FAIL loop_count got %0d exp 4", n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i < n && got[i] !== words[i]) begin
                errors++; $display("FAIL loop_word%0d got %02h exp %02h", i, got[i], words[i]);
            end
        end
        guard = 0;
        while (tx_busy && guard < 1000) begin @(negedge pclk); guard++; end
        repeat (40) @(negedge pclk);
        loop_en = 1'b0;
        rx_ready = 1'b0;
        checks++;
        if ((fer_cnt - fer0) + (ovr_cnt - ovr0) + (per_cnt - per0) != 0) begin
            errors++; $display("FAIL loop_err_pulses got %0d exp 0", (fer_cnt - fer0) + (ovr_cnt - ovr0) + (per_cnt - per0));
        end
    endtask

    task automatic test_overrun();
        int ovr0;
        ovr0 = ovr_cnt;
        dvsr = 16'd2;
        rx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send_rx_frame(8'(i), 1'b1);
        repeat (4) @(negedge pclk);
        checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL ovr_level4 got %0d exp 4", rx_level); end
        checks++; if (ovr_cnt != ovr0) begin errors++; $display("FAIL ovr_early got %0d exp 0", ovr_cnt - ovr0); end
        send_rx_frame(8'h05, 1'b1);
        repeat (4) @(negedge pclk);
        checks++; if (ovr_cnt - ovr0 != 1) begin errors++; $display("FAIL ovr_pulse got %0d exp 1", ovr_cnt - ovr0); end
        checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL ovr_level_after got %0d exp 4", rx_level); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i)) begin
                errors++; $display("FAIL ovr_pop%0d got v=%b d=%02h exp v=1 d=%02h", i, rx_valid, rx_data, i);
            end
            rx_ready = 1'b1;
            @(negedge pclk);
            rx_ready = 1'b0;
        end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %b exp 0", rx_valid); end
    endtask

    task automatic test_frame_err();
        int fer0;
        fer0 = fer_cnt;
        send_rx_frame(8'h3C, 1'b0);
        repeat (40) @(negedge pclk);
        checks++; if (fer_cnt - fer0 != 1) begin errors++; $display("FAIL frame_err_pulse got %0d exp 1", fer_cnt - fer0); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL frame_err_valid got %b exp 0", rx_valid); end
    endtask

    task automatic test_glitch();
        int fer0, ovr0;
        fer0 = fer_cnt; ovr0 = ovr_cnt;
        @(negedge pclk);
        rx_drv = 1'b0;
        repeat (6) @(negedge pclk);
        rx_drv = 1'b1;
        repeat (100) @(negedge pclk);
        checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", rx_level); end
        checks++; if (fer_cnt != fer0 || ovr_cnt != ovr0) begin errors++; $display("FAIL glitch_err got %0d exp 0", (fer_cnt - fer0) + (ovr_cnt - ovr0)); end
        send_rx_frame(8'h81, 1'b1);
        repeat (4) @(negedge pclk);
        checks++;
        if (rx_valid !== 1'b1 || rx_data !== 8'h81) begin
            errors++; $display("FAIL glitch_next_frame got v=%b d=%02h exp v=1 d=81", rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge pclk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset_mid_tx();
        int bad;
        dvsr = 16'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            tx_data = 8'h11 * 8'(i + 1);
            tx_valid = 1'b1;
        end
        @(negedge pclk);
        tx_valid = 1'b0;
        repeat (150) @(negedge pclk);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b exp 1", tx_busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL rst_mid_tx got %b exp 1", tx); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b exp 0", tx_busy); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got %b exp 1", tx_ready); end
        repeat (5) @(negedge pclk);
        rst_n = 1'b1;
        bad = 0;
        repeat (1500) begin
            @(negedge pclk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rst_mid_idle got %0d active cycles exp 0", bad); end
    endtask

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid_tx();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
